pc_stack_unit: RTL and testbench

Call/interrupt save and return/RTI restore engine for the program counter. On CALL or interrupt it pushes the 32-bit return PC, plus flags for interrupts, onto the data-memory stack over a 16-bit handshaked port. On RET/RTI it pops them back and delivers the restored PC as a one-cycle-valid word to the PC register's return path. It owns the stack pointer and stalls fetch via `Busy` while a transfer is in flight.

---
 rtl/pc_stack_unit.sv | 212 +++++++++++++++++++++
 tb/tb_pc_stack_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: saves the return PC (and flags for interrupts) to the data-memory stack on
// CALL/INT and restores them on RET/RTI over a 16-bit handshaked memory port. Owns the stack
// pointer and holds Busy high while any transfer is in flight.
module pc_stack_unit #(
  parameter int unsigned     SP_W    = 12,
  parameter logic [SP_W-1:0] SP_INIT = 12'hFFF
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            CallReq,
  input  logic            IntReq,
  input  logic            RetReq,
  input  logic            RtiReq,
  input  logic [31:0]     ReturnPC,
  input  logic [3:0]      FlagsIn,
  output logic            MemReq,
  output logic            MemWe,
  output logic [SP_W-1:0] MemAddr,
  output logic [15:0]     MemWData,
  input  logic [15:0]     MemRData,
  input  logic            MemAck,
  output logic [31:0]     RetPC,
  output logic            RetValid,
  output logic [3:0]      FlagsOut,
  output logic            FlagsValid,
  output logic            StackErr,
  output logic            Busy,
  output logic [SP_W-1:0] Sp
);

  localparam logic [SP_W-1:0] SP_ONE = {{(SP_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StIdle,
    StPushHi,
    StPushLo,
    StPushFlg,
    StPopFlg,
    StPopLo,
    StPopHi
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [SP_W-1:0] r_sp;
  logic [31:0]     r_save_pc;    // PC captured on push accept
  logic [3:0]      r_save_flags; // flags captured on interrupt accept
  logic            r_with_flags; // current transfer carries a flags word (INT or RTI)
  logic [15:0]     r_pop_lo;
  logic [3:0]      r_pop_flags;
  logic [31:0]     r_ret_pc;
  logic            r_ret_valid;
  logic [3:0]      r_flags_out;
  logic            r_flags_valid;
  logic            r_stack_err;

  logic w_idle;
  logic w_sel_int;
  logic w_sel_call;
  logic w_sel_rti;
  logic w_sel_ret;
  logic w_push_acc;
  logic w_pop_req;
  logic w_empty;
  logic w_beat_done;
  logic w_is_push;
  logic w_is_pop;

  // Fixed-priority request arbitration; losers are simply dropped
  always_comb begin
    w_idle     = (r_state == StIdle);
    w_sel_int  = IntReq;
    w_sel_call = !IntReq && CallReq;
    w_sel_rti  = !IntReq && !CallReq && RtiReq;
    w_sel_ret  = !IntReq && !CallReq && !RtiReq && RetReq;
    w_push_acc = w_idle && (w_sel_int || w_sel_call);
    w_pop_req  = w_idle && (w_sel_rti || w_sel_ret);
    w_empty    = (r_sp == SP_INIT);
    w_is_push  = (r_state == StPushHi) || (r_state == StPushLo) || (r_state == StPushFlg);
    w_is_pop   = (r_state == StPopFlg) || (r_state == StPopLo) || (r_state == StPopHi);
    w_beat_done = (w_is_push || w_is_pop) && MemAck;
  end

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic: each beat advances only on its acknowledge
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_push_acc) begin
          w_state_d = StPushHi;
        end else if (w_pop_req && !w_empty) begin
          w_state_d = w_sel_rti ? StPopFlg : StPopLo;
        end
      end
      StPushHi:  if (MemAck) w_state_d = StPushLo;
      StPushLo:  if (MemAck) w_state_d = r_with_flags ? StPushFlg : StIdle;
      StPushFlg: if (MemAck) w_state_d = StIdle;
      StPopFlg:  if (MemAck) w_state_d = StPopLo;
      StPopLo:   if (MemAck) w_state_d = StPopHi;
      StPopHi:   if (MemAck) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // Memory port driven purely from registered state so it stays stable across wait cycles
  always_comb begin
    MemReq   = 1'b0;
    MemWe    = 1'b0;
    MemAddr  = '0;
    MemWData = 16'h0000;
    if (w_is_push) begin
      MemReq  = 1'b1;
      MemWe   = 1'b1;
      MemAddr = r_sp;
      unique case (r_state)
        StPushHi: MemWData = r_save_pc[31:16];
        StPushLo: MemWData = r_save_pc[15:0];
        default:  MemWData = {12'h000, r_save_flags};
      endcase
    end else if (w_is_pop) begin
      MemReq  = 1'b1;
      MemAddr = r_sp + SP_ONE; // pre-increment: SP always names the next free word
    end
  end

  // Stack pointer: post-decrement on push beats, pre-increment on pop beats
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sp <= SP_INIT;
    end else if (w_beat_done) begin
      if (w_is_push) begin
        r_sp <= r_sp - SP_ONE;
      end else begin
        r_sp <= r_sp + SP_ONE;
      end
    end
  end

  // Capture the push payload and transfer kind on accept
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_save_pc    <= 32'h0;
      r_save_flags <= 4'h0;
      r_with_flags <= 1'b0;
    end else if (w_push_acc) begin
      r_save_pc    <= ReturnPC;
      r_save_flags <= FlagsIn;
      r_with_flags <= w_sel_int;
    end else if (w_pop_req && !w_empty) begin
      r_with_flags <= w_sel_rti;
    end
  end

  // Collect the partial pop words ahead of the final (high-half) beat
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pop_lo    <= 16'h0;
      r_pop_flags <= 4'h0;
    end else if (MemAck) begin
      if (r_state == StPopFlg) r_pop_flags <= MemRData[3:0];
      if (r_state == StPopLo)  r_pop_lo    <= MemRData;
    end
  end

  // Restored PC/flags and their one-cycle pulses, coincident with the return to idle
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ret_pc      <= 32'h0;
      r_ret_valid   <= 1'b0;
      r_flags_out   <= 4'h0;
      r_flags_valid <= 1'b0;
    end else begin
      r_ret_valid   <= 1'b0;
      r_flags_valid <= 1'b0;
      if ((r_state == StPopHi) && MemAck) begin
        r_ret_pc    <= {MemRData, r_pop_lo};
        r_ret_valid <= 1'b1;
        if (r_with_flags) begin
          r_flags_out   <= r_pop_flags;
          r_flags_valid <= 1'b1;
        end
      end
    end
  end

  // Underflow: a pop accepted on an empty stack touches no memory and just flags an error
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stack_err <= 1'b0;
    end else begin
      r_stack_err <= w_pop_req && w_empty;
    end
  end

  assign RetPC      = r_ret_pc;
  assign RetValid   = r_ret_valid;
  assign FlagsOut   = r_flags_out;
  assign FlagsValid = r_flags_valid;
  assign StackErr   = r_stack_err;
  assign Busy       = !w_idle;
  assign Sp         = r_sp;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Randomized self-checking bench for pc_stack_unit. A word-addressed memory array plus a
// scalar stack pointer model the stack; expected beats and restored values are computed
// from the push/pop rules, and the bench also acts as the handshaked memory.
module tb_pc_stack_unit;

  logic        Clk;
  logic        Rst_n;
  logic        CallReq, IntReq, RetReq, RtiReq;
  logic [31:0] ReturnPC;
  logic [3:0]  FlagsIn;
  logic        MemReq, MemWe;
  logic [11:0] MemAddr;
  logic [15:0] MemWData, MemRData;
  logic        MemAck;
  logic [31:0] RetPC;
  logic        RetValid;
  logic [3:0]  FlagsOut;
  logic        FlagsValid, StackErr, Busy;
  logic [11:0] Sp;

  pc_stack_unit #(.SP_W(12), .SP_INIT(12'hFFF)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .CallReq(CallReq), .IntReq(IntReq), .RetReq(RetReq), .RtiReq(RtiReq),
    .ReturnPC(ReturnPC), .FlagsIn(FlagsIn),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck),
    .RetPC(RetPC), .RetValid(RetValid), .FlagsOut(FlagsOut), .FlagsValid(FlagsValid),
    .StackErr(StackErr), .Busy(Busy), .Sp(Sp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference state
  logic [15:0] mem [4096];
  logic [11:0] sp_m;
  logic [31:0] exp_ret_pc;
  logic [3:0]  exp_flags_out;
  int          n_checks;
  int          n_errs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_reqs(input logic [3:0] r);
    IntReq  = r[3];
    CallReq = r[2];
    RtiReq  = r[1];
    RetReq  = r[0];
  endtask

  // Model reset state
  task automatic model_reset();
    sp_m          = 12'hFFF;
    exp_ret_pc    = 32'h0;
    exp_flags_out = 4'h0;
  endtask

  // reqs = {Int, Call, Rti, Ret}; called and returns at a negedge with the DUT idle
  task automatic run_op(input logic [3:0] reqs, input logic [31:0] pc, input logic [3:0] flg,
                        input int wmin, input int wmax);
    int          kind; // 0 none, 1 int, 2 call, 3 rti, 4 ret
    int          nb;
    int          w;
    logic [11:0] a [3];
    logic [15:0] d [3];
    logic        we;
    logic [11:0] sp_now;
    if (reqs[3])      kind = 1;
    else if (reqs[2]) kind = 2;
    else if (reqs[1]) kind = 3;
    else if (reqs[0]) kind = 4;
    else              kind = 0;

    set_reqs(reqs);
    ReturnPC = pc;
    FlagsIn  = flg;
    @(negedge Clk);
    set_reqs(4'b0000);
    ReturnPC = $urandom;
    FlagsIn  = 4'($urandom);

    if (kind == 0) begin
      check("idle_memreq", {31'b0, MemReq}, 32'd0);
      check("idle_busy", {31'b0, Busy}, 32'd0);
      return;
    end

    if (kind >= 3 && sp_m == 12'hFFF) begin
      check("uf_err", {31'b0, StackErr}, 32'd1);
      check("uf_retvalid", {31'b0, RetValid}, 32'd0);
      check("uf_flagsvalid", {31'b0, FlagsValid}, 32'd0);
      check("uf_memreq", {31'b0, MemReq}, 32'd0);
      check("uf_busy", {31'b0, Busy}, 32'd0);
      check("uf_sp", {20'b0, Sp}, {20'b0, sp_m});
      @(negedge Clk);
      check("uf_err_drop", {31'b0, StackErr}, 32'd0);
      check("uf_memreq2", {31'b0, MemReq}, 32'd0);
      return;
    end

    we = (kind <= 2);
    nb = (kind == 1 || kind == 3) ? 3 : 2;
    for (int i = 0; i < nb; i++) begin
      if (we) begin
        a[i] = sp_m - 12'(i);
        d[i] = (i == 0) ? pc[31:16] : (i == 1) ? pc[15:0] : {12'h000, flg};
      end else begin
        a[i] = sp_m + 12'(i + 1);
        d[i] = mem[a[i]];
      end
    end

    for (int i = 0; i < nb; i++) begin
      w = $urandom_range(wmax, wmin);
      sp_now = we ? sp_m - 12'(i) : sp_m + 12'(i);
      for (int k = 0; k <= w; k++) begin
        check("beat_busy", {31'b0, Busy}, 32'd1);
        check("beat_req", {31'b0, MemReq}, 32'd1);
        check("beat_we", {31'b0, MemWe}, {31'b0, we});
        check("beat_addr", {20'b0, MemAddr}, {20'b0, a[i]});
        check("beat_sp", {20'b0, Sp}, {20'b0, sp_now});
        if (we) check("beat_wdata", {16'b0, MemWData}, {16'b0, d[i]});
        // Requests while busy must be ignored
        if ($urandom_range(2, 0) == 0) set_reqs(4'($urandom));
        MemAck   = (k == w);
        MemRData = (k == w && !we) ? d[i] : 16'($urandom);
        @(negedge Clk);
        set_reqs(4'b0000);
        MemAck = 1'b0;
      end
    end

    if (we) begin
      for (int i = 0; i < nb; i++) mem[a[i]] = d[i];
      sp_m = sp_m - 12'(nb);
    end else begin
      sp_m = sp_m + 12'(nb);
      if (kind == 3) begin
        exp_flags_out = d[0][3:0];
        exp_ret_pc    = {d[2], d[1]};
      end else begin
        exp_ret_pc = {d[1], d[0]};
      end
    end

    check("end_busy", {31'b0, Busy}, 32'd0);
    check("end_memreq", {31'b0, MemReq}, 32'd0);
    check("end_sp", {20'b0, Sp}, {20'b0, sp_m});
    check("end_retvalid", {31'b0, RetValid}, {31'b0, (kind >= 3)});
    check("end_flagsvalid", {31'b0, FlagsValid}, {31'b0, (kind == 3)});
    check("end_stackerr", {31'b0, StackErr}, 32'd0);
    check("end_retpc", RetPC, exp_ret_pc);
    check("end_flagsout", {28'b0, FlagsOut}, {28'b0, exp_flags_out});
    @(negedge Clk);
    check("pulse_retvalid", {31'b0, RetValid}, 32'd0);
    check("pulse_flagsvalid", {31'b0, FlagsValid}, 32'd0);
  endtask

  initial begin
    logic [3:0] r;
    int         depth;
    n_checks = 0;
    n_errs   = 0;
    Rst_n    = 1'b0;
    set_reqs(4'b0000);
    ReturnPC = 32'h0;
    FlagsIn  = 4'h0;
    MemAck   = 1'b0;
    MemRData = 16'h0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
    model_reset();

    #12;
    check("rst_sp", {20'b0, Sp}, 32'h0000_0FFF);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_memreq", {31'b0, MemReq}, 32'd0);
    check("rst_retpc", RetPC, 32'h0);
    check("rst_retvalid", {31'b0, RetValid}, 32'd0);
    check("rst_flagsout", {28'b0, FlagsOut}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 5; i++) run_op(4'b0000, 32'h0, 4'h0, 0, 0);

    // Underflow right after reset
    run_op(4'b0001, 32'h0, 4'h0, 0, 0);
    run_op(4'b0010, 32'h0, 4'h0, 0, 0);

    // Directed CALL / INT / RTI / RET
    run_op(4'b0100, 32'h1234_5678, 4'h0, 0, 0);
    run_op(4'b1000, 32'hCAFE_0010, 4'b1010, 2, 2);
    run_op(4'b0010, 32'h0, 4'h0, 0, 0);
    run_op(4'b0001, 32'h0, 4'h0, 1, 1);

    // Simultaneous Int+Call+Ret: only the interrupt runs
    run_op(4'b1101, 32'hA5A5_5A5A, 4'b0110, 0, 1);
    run_op(4'b0010, 32'h0, 4'h0, 0, 0);

    // Reset during the PUSH_LO wait
    set_reqs(4'b0100);
    ReturnPC = 32'hDEAD_BEEF;
    @(negedge Clk);
    set_reqs(4'b0000);
    MemAck = 1'b1;
    @(negedge Clk);
    MemAck = 1'b0;
    check("midrst_pre_req", {31'b0, MemReq}, 32'd1);
    check("midrst_pre_addr", {20'b0, MemAddr}, 32'h0000_0FFE);
    #2 Rst_n = 1'b0;
    #1;
    check("midrst_memreq", {31'b0, MemReq}, 32'd0);
    check("midrst_sp", {20'b0, Sp}, 32'h0000_0FFF);
    check("midrst_busy", {31'b0, Busy}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    run_op(4'b0100, 32'h0BAD_F00D, 4'h0, 0, 1);
    run_op(4'b0001, 32'h0, 4'h0, 0, 0);

    // Randomized mix of pushes and pops with random wait states
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(3, 0) == 0) r = 4'($urandom);
      else r = 4'b0001 << $urandom_range(3, 0);
      depth = 12'hFFF - sp_m;
      // Avoid partial underflow: pops need a full frame or an empty stack
      if (!r[3] && !r[2] && (r[1] || r[0])) begin
        if (depth != 0 && depth < (r[1] ? 3 : 2)) r = 4'b0100;
      end
      run_op(r, $urandom, 4'($urandom), 0, 3);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
